seq_det_arbiter: RTL and testbench

Round-robin controller that time-shares a single bit-serial "11" sequence detector (ports clk, reset, in_bit, detected) among N_REQ serial requesters. It grants one requester at a time, clears the detector, streams a fixed-length frame from that requester into it, counts the detections, and then reports the count. The block sits between the requester channels and the detector instance.

---
 rtl/seq_det_arbiter_if.sv | 43 ++++
 rtl/seq_det_arbiter.sv | 129 ++++++++++++
 tb/tb_seq_det_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_arbiter_if.sv
// seq_det_arbiter_if
//   Bundles the requester channels and the shared "11" detector hookup that
//   seq_det_arbiter time-shares.
//   slave  : used by the arbiter (drives grant, detector controls, report).
//   master : used by the requester/detector side.
//   Signals:
//     req, in_bits   per-requester request level and serial data bit
//     grant          one-hot ownership of the detector (one bit per cycle)
//     det_reset      detector reset
//     det_bit        detector serial input
//     detected       detector output (registered, Moore)
//     done           one-cycle frame-end pulse
//     done_id        requester served (valid with done)
//     match_count    detections in the frame (valid with done)
//     aborted        frame was cut short (valid with done)
interface seq_det_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 8
);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] in_bits;
    logic [N_REQ-1:0] grant;
    logic             det_reset;
    logic             det_bit;
    logic             detected;
    logic             done;
    logic [IW-1:0]    done_id;
    logic [CW-1:0]    match_count;
    logic             aborted;

    modport slave (
        input  req, in_bits, detected,
        output grant, det_reset, det_bit, done, done_id, match_count, aborted
    );

    modport master (
        output req, in_bits, detected,
        input  grant, det_reset, det_bit, done, done_id, match_count, aborted
    );
endinterface

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter
//   Round-robin controller sharing one bit-serial "11" detector among N_REQ
//   serial requesters. Each granted frame: clear the detector, stream
//   FRAME_LEN bits from the owner, count detections, report the count.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    seq_det_arbiter_if.slave (requests, data, grant, detector
//            control, frame report)
module seq_det_arbiter #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic                clk,
    input  logic                reset,
    seq_det_arbiter_if.slave    bus
);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, REPORT} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [CW-1:0] bit_idx;
    logic [CW-1:0] cnt;
    logic          aborted_r;

    logic          done_r;
    logic [IW-1:0] done_id_r;
    logic [CW-1:0] match_count_r;
    logic          aborted_o;

    logic [N_REQ-1:0] grant_c;

    // First set request at or after ptr, searching circularly.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] sel;
        int            idx;
        sel = ptr;
        // Walk backwards so the closest candidate to ptr is the last write.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (r[idx]) sel = IW'(idx);
        end
        return sel;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] cur);
        return IW'((int'(cur) + 1) % N_REQ);
    endfunction

    // Counter holds at FRAME_LEN; a legal frame never reaches it.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= CW'(FRAME_LEN)) ? c : c + 1'b1;
    endfunction

    always_comb begin
        grant_c = '0;
        if (state == STREAM) grant_c[owner] = 1'b1;
    end

    assign bus.grant       = grant_c;
    assign bus.det_bit     = (state == STREAM) ? bus.in_bits[owner] : 1'b0;
    assign bus.det_reset   = reset | (state == CLR);
    assign bus.done        = done_r;
    assign bus.done_id     = done_id_r;
    assign bus.match_count = match_count_r;
    assign bus.aborted     = aborted_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            bit_idx       <= '0;
            cnt           <= '0;
            aborted_r     <= 1'b0;
            done_r        <= 1'b0;
            done_id_r     <= '0;
            match_count_r <= '0;
            aborted_o     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner <= rr_pick(bus.req, rr_ptr);
                        state <= CLR;
                    end
                end
                CLR: begin
                    bit_idx   <= '0;
                    cnt       <= '0;
                    aborted_r <= 1'b0;
                    state     <= STREAM;
                end
                STREAM: begin
                    // detected reflects the bit streamed in the previous cycle.
                    if (bit_idx != '0 && bus.detected) cnt <= sat_inc(cnt);
                    if (!bus.req[owner]) begin
                        aborted_r <= 1'b1;
                        state     <= DRAIN;
                    end else if (bit_idx == CW'(FRAME_LEN - 1)) begin
                        state <= DRAIN;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    // Final detector result folds straight into the report,
                    // so done lines up with the REPORT state.
                    done_r        <= 1'b1;
                    done_id_r     <= owner;
                    match_count_r <= bus.detected ? sat_inc(cnt) : cnt;
                    aborted_o     <= aborted_r;
                    state         <= REPORT;
                end
                REPORT: begin
                    rr_ptr <= next_ptr(owner);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_det_arbiter.sv
module tb_seq_det_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    seq_det_arbiter_if #(.N_REQ(4), .FRAME_LEN(8)) bus_a ();
    seq_det_arbiter_if #(.N_REQ(1), .FRAME_LEN(2)) bus_b ();

    seq_det_arbiter #(.N_REQ(4), .FRAME_LEN(8)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a.slave)
    );
    seq_det_arbiter #(.N_REQ(1), .FRAME_LEN(2)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b.slave)
    );

    // Reference "11" detector: detected=1 the cycle after two consecutive 1s.
    logic prev_a, prev_b;
    always @(posedge clk) begin
        if (bus_a.det_reset) begin
            prev_a <= 1'b0;
            bus_a.detected <= 1'b0;
        end else begin
            bus_a.detected <= prev_a & bus_a.det_bit;
            prev_a <= bus_a.det_bit;
        end
        if (bus_b.det_reset) begin
            prev_b <= 1'b0;
            bus_b.detected <= 1'b0;
        end else begin
            bus_b.detected <= prev_b & bus_b.det_bit;
            prev_b <= bus_b.det_bit;
        end
    end

    // Requesters: bit pattern in time order (bit 0 first), advance on grant.
    logic [31:0] pat_a [4];
    logic [4:0]  pos_a [4];
    logic [3:0]  ld_a;
    logic [31:0] pat_b;
    logic [4:0]  pos_b;
    logic        ld_b;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ld_a[i]) pos_a[i] <= '0;
            else if (bus_a.grant[i]) pos_a[i] <= pos_a[i] + 1'b1;
        end
        if (ld_b) pos_b <= '0;
        else if (bus_b.grant[0]) pos_b <= pos_b + 1'b1;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) bus_a.in_bits[i] = pat_a[i][pos_a[i]];
        bus_b.in_bits[0] = pat_b[pos_b];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all();
        ld_a = 4'hF;
        tick();
        ld_a = 4'h0;
    endtask

    typedef struct {
        int          rq;
        logic [31:0] pat;
        int          cnt;
    } vec_t;

    vec_t vecs [6];

    // One isolated frame from requester rq on the default-size instance.
    task automatic run_single(input int rq, input logic [31:0] p, input int exp_cnt);
        int n_done;
        int gcnt;
        int multi;
        n_done = -1;
        gcnt = 0;
        multi = 0;
        pat_a[rq] = p;
        load_all();
        bus_a.req[rq] = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if ($countones(bus_a.grant) > 1) multi = 1;
            if (bus_a.grant == (4'b0001 << rq)) gcnt++;
            if (bus_a.done) begin
                n_done = n;
                break;
            end
        end
        chk("single_occupancy", n_done + 1, 12);
        chk("single_grant_cycles", gcnt, 8);
        chk("single_multi_hot", multi, 0);
        chk("single_done_id", bus_a.done_id, rq);
        chk("single_match_count", bus_a.match_count, exp_cnt);
        chk("single_aborted", bus_a.aborted, 0);
        bus_a.req[rq] = 1'b0;
        tick();
        chk("single_done_pulse", bus_a.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gseen;
        int first_grant;
        int k;
        int ids [5];
        int cnts [5];
        int when [5];
        int multi;
        int n_done;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.req = '0;
        bus_b.req = '0;
        ld_a = 4'hF;
        ld_b = 1'b1;
        for (int i = 0; i < 4; i++) pat_a[i] = '0;
        pat_b = '0;

        vecs[0] = '{rq: 0, pat: 32'h0000_006C, cnt: 2}; // 0,0,1,1,0,1,1,0
        vecs[1] = '{rq: 2, pat: 32'h0000_00FF, cnt: 7}; // all ones
        vecs[2] = '{rq: 2, pat: 32'h0000_0069, cnt: 1}; // 1,0,0,1,0,1,1,0
        vecs[3] = '{rq: 3, pat: 32'h0000_0000, cnt: 0}; // all zeros
        vecs[4] = '{rq: 1, pat: 32'h0000_0055, cnt: 0}; // alternating
        vecs[5] = '{rq: 1, pat: 32'h0000_00C0, cnt: 1}; // pair ends frame

        repeat (3) tick();
        chk("rst_grant", bus_a.grant, 0);
        chk("rst_det_reset", bus_a.det_reset, 1);
        chk("rst_det_bit", bus_a.det_bit, 0);
        chk("rst_done", bus_a.done, 0);
        chk("rst_done_id", bus_a.done_id, 0);
        chk("rst_match_count", bus_a.match_count, 0);
        chk("rst_aborted", bus_a.aborted, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        ld_a = 4'h0;
        ld_b = 1'b0;
        tick();
        chk("post_rst_det_reset", bus_a.det_reset, 0);

        for (int v = 0; v < 6; v++) run_single(vecs[v].rq, vecs[v].pat, vecs[v].cnt);

        // Abort: requester 1 drops req at bit_idx 3 after 1,1,1.
        pat_a[1] = 32'h0000_0007;
        load_all();
        bus_a.req[1] = 1'b1;
        gseen = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus_a.grant[1]) gseen++;
            if (gseen == 4) begin
                bus_a.req[1] = 1'b0;
                break;
            end
        end
        chk("abort_reached_bit3", gseen, 4);
        tick();
        chk("abort_grant_drop", bus_a.grant, 0);
        chk("abort_drain_det_bit", bus_a.det_bit, 0);
        tick();
        chk("abort_done", bus_a.done, 1);
        chk("abort_done_id", bus_a.done_id, 1);
        chk("abort_match_count", bus_a.match_count, 2);
        chk("abort_flag", bus_a.aborted, 1);
        tick();

        // Reset at bit_idx 4 of requester 0's frame; rr_ptr is 2 beforehand.
        pat_a[0] = 32'hFFFF_FFFF;
        pat_a[1] = 32'h0;
        pat_a[3] = 32'h0;
        load_all();
        bus_a.req = 4'b0001;
        gseen = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus_a.grant[0]) gseen++;
            if (gseen == 5) break;
        end
        chk("midrst_reached_bit4", gseen, 5);
        rst_a = 1'b1;
        bus_a.req = 4'b1010;
        tick();
        chk("midrst_grant", bus_a.grant, 0);
        chk("midrst_det_reset", bus_a.det_reset, 1);
        chk("midrst_done", bus_a.done, 0);
        tick();
        chk("midrst_done_hold", bus_a.done, 0);
        rst_a = 1'b0;
        first_grant = 0;
        n_done = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (first_grant == 0 && bus_a.grant != 0) first_grant = int'(bus_a.grant);
            if (bus_a.done) begin
                n_done = n;
                break;
            end
        end
        chk("midrst_first_grant", first_grant, 2);
        chk("midrst_first_done_id", bus_a.done_id, 1);
        chk("midrst_first_count", bus_a.match_count, 0);
        bus_a.req[1] = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (bus_a.done) break;
        end
        chk("midrst_second_done", bus_a.done, 1);
        chk("midrst_second_done_id", bus_a.done_id, 3);
        bus_a.req = '0;
        tick();

        // All four requesting continuously with all-ones frames.
        for (int i = 0; i < 4; i++) pat_a[i] = 32'hFFFF_FFFF;
        load_all();
        bus_a.req = 4'b1111;
        k = 0;
        multi = 0;
        for (int i = 0; i < 5; i++) begin
            ids[i] = -1;
            cnts[i] = -1;
            when[i] = -100;
        end
        for (int n = 1; n <= 100; n++) begin
            tick();
            if ($countones(bus_a.grant) > 1) multi = 1;
            if (bus_a.done) begin
                ids[k] = int'(bus_a.done_id);
                cnts[k] = int'(bus_a.match_count);
                when[k] = n;
                k++;
                if (k == 5) begin
                    bus_a.req = '0;
                    break;
                end
            end
        end
        chk("rr_done_count", k, 5);
        chk("rr_multi_hot", multi, 0);
        chk("rr_first_latency", when[0], 11);
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", ids[i], i % 4);
            chk("rr_match_count", cnts[i], 7);
            if (i > 0) chk("rr_spacing", when[i] - when[i-1], 12);
        end
        tick();

        // Minimal instance: one requester, two-bit frame 1,1.
        pat_b = 32'h0000_0003;
        ld_b = 1'b1;
        tick();
        ld_b = 1'b0;
        bus_b.req = 1'b1;
        n_done = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (bus_b.done) begin
                n_done = n;
                break;
            end
        end
        chk("small_occupancy", n_done + 1, 6);
        chk("small_done_id", bus_b.done_id, 0);
        chk("small_match_count", bus_b.match_count, 1);
        chk("small_aborted", bus_b.aborted, 0);
        bus_b.req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
